// File: rtl/port_reader_pkg.sv
// port_reader_pkg: shared defaults, FSM state encoding and index helpers for port_reader.
package port_reader_pkg;
  localparam int PORT_NUB_TOTAL = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/port_reader_rr_pick.sv
// rr_pick: round-robin first-one finder starting the search at index start.
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] grant,
  output logic         any
);
  logic [N-1:0] rot;
  int off;
  // bit k of rot is req[(start + k) mod N]
  assign rot = N'({req, req} >> start);
  assign any = |req;
  always_comb begin
    off = 0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? k : off;
    grant = W'((int'(start) + off) % N);
  end
endmodule

// File: rtl/port_reader.sv
// port_reader: drains one switch output port's source queues in round-robin bursts
// into a 2-entry skid buffer with a valid/ready output.
module port_reader
  import port_reader_pkg::*;
#(
  parameter int PORT_NUB = PORT_NUB_TOTAL,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PORT_ID = 0,
  parameter int BURST_MAX = 8,
  localparam int WIDTH_SEL = $clog2(PORT_NUB)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PORT_NUB-1:0]   empty,
  output logic [WIDTH_SEL-1:0]  rd_sel,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [WIDTH_SEL-1:0]  out_src,
  output logic [31:0]           word_count
);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  if (PORT_ID >= PORT_NUB) begin : g_bad_port_id
    $error("port_reader: PORT_ID must be below PORT_NUB");
  end
  logic [0:0] state_q, state_d;
  logic [WIDTH_SEL-1:0] src_q, src_d, last_src_q, last_src_d, fly_src_q, start_idx, grant;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fly_q, any_req, pop, credit_ok, last_beat;
  logic [1:0] count_q;
  logic wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [WIDTH_SEL-1:0] tag_q [2];
  rr_pick #(.N(PORT_NUB)) u_pick (
    .req   (~empty),
    .start (start_idx),
    .grant (grant),
    .any   (any_req)
  );
  assign start_idx = WIDTH_SEL'(wrap_inc(int'(last_src_q), PORT_NUB));
  assign out_valid = count_q != 2'd0;
  assign out_data  = data_q[rd_ptr_q];
  assign out_src   = tag_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;
  // a word leaving this cycle frees its slot, so full-rate streaming never stalls
  assign credit_ok = (int'(count_q) - int'(pop) + int'(fly_q)) < 2;
  assign rd_sel    = src_q;
  assign rd_en     = (state_q == BURST) && !empty[src_q] && credit_ok;
  assign last_beat = rd_en && (cnt_q == CNT_W'(BURST_MAX - 1));
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    last_src_d = last_src_q;
    cnt_d = cnt_q + CNT_W'(rd_en);
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (enable && any_req) begin
        state_d = BURST;
        src_d = grant;
      end
    end else if (empty[src_q] || !enable || last_beat) begin
      state_d = IDLE;
      last_src_d = src_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q <= '0;
      last_src_q <= WIDTH_SEL'(PORT_NUB - 1);
      cnt_q <= '0;
      fly_q <= 1'b0;
      fly_src_q <= '0;
      count_q <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      word_count <= '0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      last_src_q <= last_src_d;
      cnt_q <= cnt_d;
      fly_q <= rd_en;
      fly_src_q <= src_q;
      count_q <= count_q + {1'b0, fly_q} - {1'b0, pop};
      if (fly_q) begin
        data_q[wr_ptr_q] <= rd_data;
        tag_q[wr_ptr_q] <= fly_src_q;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (pop && word_count != 32'hFFFF_FFFF) word_count <= word_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_port_reader.sv
// tb_port_reader: randomized scoreboard bench for port_reader with a queue-based switch model.
module tb_port_reader;
  localparam int N = 4;
  localparam int BM = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic out_ready = 1'b1;
  logic [N-1:0] empty;
  logic [1:0] rd_sel, out_src;
  logic rd_en, out_valid;
  logic [DW-1:0] rd_data, out_data;
  logic [31:0] word_count;
  port_reader #(.PORT_NUB(N), .DATA_WIDTH(DW), .PORT_ID(1), .BURST_MAX(BM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .empty      (empty),
    .rd_sel     (rd_sel),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .word_count (word_count)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] sw_mem [N][64];
  int sw_head [N];
  int sw_tail [N];
  logic [DW-1:0] exp_q [N][$];
  int nchk = 0, nerr = 0, xfer = 0, base = 0, seq = 0, mlast = N - 1;
  int ms[$], ml[$], rs[$], rl[$], rg[$];
  always_comb for (int i = 0; i < N; i++) empty[i] = sw_head[i] == sw_tail[i];
  // switch model: one word popped per rd_en, data returned on the following cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      for (int i = 0; i < N; i++) sw_head[i] <= sw_tail[i];
    end else if (rd_en) begin
      rd_data <= sw_mem[rd_sel][sw_head[rd_sel] % 64];
      sw_head[rd_sel] <= sw_head[rd_sel] + 1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  logic stall = 1'b0;
  logic [DW-1:0] hold_d;
  logic [1:0] hold_s;
  int run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
      run = 0;
    end else begin
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_d));
        chk("hold_src", 32'(out_src), 32'(hold_s));
      end
      stall = out_valid && !out_ready;
      hold_d = out_data;
      hold_s = out_src;
      if (out_valid && out_ready) begin
        xfer++;
        if (exp_q[out_src].size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL extra_word: got src %0d data %0h expected no word", out_src, out_data);
        end else chk("word", 32'(out_data), 32'(exp_q[out_src].pop_front()));
      end
      if (rd_en) begin
        chk("rd_en_nonempty", 32'(empty[rd_sel]), 32'd0);
        run++;
      end else if (run > 0) begin
        chk("burst_le_max", 32'(run <= BM), 32'd1);
        run = 0;
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input int s, input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = {2'(s), 14'(seq)};
      seq++;
      sw_mem[s][sw_tail[s] % 64] = w;
      sw_tail[s] = sw_tail[s] + 1;
      exp_q[s].push_back(w);
    end
  endtask
  // expected bursts with out_ready held high: round-robin from last source, min(BM, remaining)
  task automatic model(input int c0, input int c1, input int c2, input int c3);
    int rem [N];
    int s, n, tot;
    rem[0] = c0; rem[1] = c1; rem[2] = c2; rem[3] = c3;
    tot = c0 + c1 + c2 + c3;
    ms.delete();
    ml.delete();
    while (tot > 0) begin
      s = mlast;
      do s = (s + 1) % N; while (rem[s] == 0);
      n = rem[s] < BM ? rem[s] : BM;
      ms.push_back(s);
      ml.push_back(n);
      rem[s] -= n;
      tot -= n;
      mlast = s;
    end
  endtask
  function automatic bit busy();
    bit b = out_valid || rd_en;
    for (int i = 0; i < N; i++) b |= sw_head[i] != sw_tail[i];
    return b;
  endfunction
  task automatic wait_rd();
    int n = 0;
    @(negedge clk);
    while (!rd_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rd_en", 32'(rd_en), 32'd1);
  endtask
  task automatic drain();
    int q = 0, n = 0;
    while (q < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      q = busy() ? 0 : q + 1;
    end
    chk("drain_done", 32'(q >= 4), 32'd1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int cur, len, gap, tot;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_sel", 32'(rd_sel), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_word_count", word_count, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    enable = 1'b1;
    cyc(1);
    model(0, 0, 3, 0);
    load(2, 3);
    wait_rd();
    chk("a_sel", 32'(rd_sel), 32'(ms[0]));
    @(negedge clk);
    chk("a_rd2", 32'(rd_en), 32'd1);
    chk("a_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("a_rd3", 32'(rd_en), 32'd1);
    chk("a_lat2", 32'(out_valid), 32'd1);
    chk("a_src", 32'(out_src), 32'd2);
    @(negedge clk);
    chk("a_rd_stop", 32'(rd_en), 32'd0);
    drain();
    chk("a_count", word_count, 32'd3);
    cyc(1);
    model(0, 1, 0, 0);
    load(1, 1);
    drain();
    cyc(1);
    enable = 1'b0;
    model(3, 3, 0, 0);
    load(0, 3);
    load(1, 3);
    cyc(1);
    enable = 1'b1;
    wait_rd();
    chk("b_rr_sel", 32'(rd_sel), 32'(ms[0]));
    drain();
    cyc(1);
    enable = 1'b0;
    model(10, 0, 0, 10);
    load(0, 10);
    load(3, 10);
    cyc(1);
    enable = 1'b1;
    cur = -1; len = 0; gap = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (rd_en && len > 0 && int'(rd_sel) == cur) len++;
      else begin
        if (len > 0) begin
          rs.push_back(cur); rl.push_back(len); rg.push_back(gap);
          len = 0; gap = 0;
        end
        if (rd_en) begin
          cur = int'(rd_sel);
          len = 1;
        end else gap++;
      end
    end
    if (len > 0) begin
      rs.push_back(cur); rl.push_back(len); rg.push_back(gap);
    end
    chk("c_runs", 32'(rs.size()), 32'(ms.size()));
    for (int i = 0; i < ms.size(); i++) begin
      if (i < rs.size()) begin
        chk("c_burst_src", 32'(rs[i]), 32'(ms[i]));
        chk("c_burst_len", 32'(rl[i]), 32'(ml[i]));
        if (i > 0 && ml[i-1] == BM) chk("c_burst_gap", 32'(rg[i]), 32'd1);
      end
    end
    drain();
    cyc(1);
    load(2, 8);
    wait_rd();
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("d_rd_stop", 32'(rd_en), 32'd0);
        chk("d_valid", 32'(out_valid), 32'd1);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    cyc(1);
    load(1, 8);
    wait_rd();
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("e_rd_low", 32'(rd_en), 32'd0);
    end
    repeat (4) @(negedge clk);
    chk("e_drained", 32'(out_valid), 32'd0);
    cyc(1);
    enable = 1'b1;
    drain();
    for (int r = 0; r < 4; r++) begin
      cyc(1);
      for (int s = 0; s < N; s++) load(s, int'($urandom_range(0, 10)));
      for (int c = 0; c < 60; c++) begin
        @(posedge clk);
        #1;
        out_ready = $urandom_range(0, 3) != 0;
        enable = $urandom_range(0, 7) != 0;
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      enable = 1'b1;
      drain();
    end
    cyc(1);
    load(0, 8);
    wait_rd();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("f_rd_en", 32'(rd_en), 32'd0);
    chk("f_rd_sel", 32'(rd_sel), 32'd0);
    chk("f_out_valid", 32'(out_valid), 32'd0);
    chk("f_out_data", 32'(out_data), 32'd0);
    chk("f_out_src", 32'(out_src), 32'd0);
    chk("f_word_count", word_count, 32'd0);
    for (int s = 0; s < N; s++) exp_q[s].delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = xfer;
    mlast = N - 1;
    cyc(1);
    model(2, 0, 0, 2);
    load(0, 2);
    load(3, 2);
    wait_rd();
    chk("f_restart_sel", 32'(rd_sel), 32'(ms[0]));
    drain();
    tot = 0;
    for (int s = 0; s < N; s++) tot += exp_q[s].size();
    chk("leftover_words", 32'(tot), 32'd0);
    chk("final_word_count", word_count, 32'(xfer - base));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
